mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter LAT, default 2: memory read latency in cycles, legal range 1..15.
REQ-002 Parameter FIXED_PRIO, default 0: 0 selects round-robin arbitration, 1 gives port 0 absolute priority.
REQ-003 clk  input  1  single clock; all state changes on posedge clk.
REQ-004 reset  input  1  synchronous, active-low reset; sampled on posedge clk.
REQ-005 req0, req1  input  1 each  access request from port 0 (instruction fetch) and port 1 (data load/store).
REQ-006 we0, we1  input  1 each  1 = write, 0 = read; qualified by req.
REQ-007 addr0, addr1  input  16 each  word address.
REQ-008 wdata0, wdata1  input  16 each  write data.
REQ-009 gnt0, gnt1  output  1 each  one-cycle pulse when the port's command is accepted and issued.
REQ-010 ack0, ack1  output  1 each  one-cycle pulse when the port's access completes.
REQ-011 rdata0, rdata1  output  16 each  read data, valid while ack is high after a read.
REQ-012 mem_en, mem_we  output  1 each  memory strobe and write enable.
REQ-013 mem_addr, mem_wdata  output  16 each  memory address and write data.
REQ-014 mem_rdata  input  16  memory read data, valid LAT cycles after the mem_en cycle.

Function
REQ-015 FSM states: IDLE, ISSUE, WAIT, RESP; only one access is outstanding at a time.
REQ-016 IDLE: with no req, stay in IDLE; with any req, latch winner index, we, addr and wdata, then go to ISSUE.
REQ-017 Arbitration with FIXED_PRIO=0: a single requester wins; with both requesting, the port not granted last wins; the last-grant pointer updates on each grant.
REQ-018 Arbitration with FIXED_PRIO=1: port 0 wins whenever req0=1.
REQ-019 ISSUE (cycle T), one cycle:
- mem_en=1; mem_we, mem_addr and mem_wdata driven from the latched command.
- gnt of the winner = 1.
- Next state WAIT.
REQ-020 WAIT: count cycles T+1..T+LAT; at the edge ending cycle T+LAT, register mem_rdata into the winner's rdata; then go to RESP.
REQ-021 RESP (cycle T+LAT+1): winner's ack=1; next state IDLE.
- Per-access occupancy is LAT+3 cycles, counting the IDLE sampling cycle.
REQ-022 Writes follow the same timing; rdata of the winner is unchanged by a write.
REQ-023 Request handling:
- A requester holds req, we, addr and wdata stable until its gnt.
- Inputs are don't-care after gnt.
- A req still high in the IDLE cycle after ack is a new request.
REQ-024 Outputs outside the stated cycles:
- mem_en, mem_we, gnt and ack are 0.
- mem_addr and mem_wdata hold their last values.
- rdata0 and rdata1 hold their last captured values.
REQ-025 A gnt or ack is never asserted to both ports in the same cycle.
REQ-026 Address 16'hFFFF passes unmodified; no address arithmetic or wrap is performed.
REQ-027 A req that drops in IDLE before it is sampled produces no grant.

Reset
REQ-028 reset=0 at a posedge sets:
- state IDLE;
- mem_en=0, mem_we=0, gnt0=0, gnt1=0, ack0=0, ack1=0;
- mem_addr=0, mem_wdata=0, rdata0=0, rdata1=0;
- wait counter 0;
- last-grant pointer = port 1, so port 0 wins the first tie.
REQ-029 Reset in ISSUE, WAIT or RESP aborts the access: no ack is produced and any later mem_rdata is ignored.
REQ-030 The first arbitration after reset release occurs in the first cycle with reset=1.

Verification (LAT=2 unless stated)
REQ-031 Single read: req0=1, we0=0, addr0=16'h0010, mem_rdata=16'hBEEF at T+2 -> mem_en and gnt0 at T, ack0 at T+3, rdata0=16'hBEEF.
REQ-032 Tie with round-robin: req0=req1=1 held continuously from reset release -> grants alternate 0,1,0,1, with gnt spacing of 5 cycles.
REQ-033 FIXED_PRIO=1: req0=req1=1 held for 3 accesses -> gnt0 three times, gnt1 never; dropping req0 -> gnt1 on the next arbitration.
REQ-034 Write on port 1: we1=1, addr1=16'hFFFF, wdata1=16'h1234 -> mem_we=1, mem_addr=16'hFFFF, mem_wdata=16'h1234 in the ISSUE cycle; ack1 at T+3; rdata1 unchanged.
REQ-035 Reset mid-access: reset=0 in cycle T+1 of a port 0 read -> no ack0, state IDLE, all outputs at their reset values, next request serviced normally.
REQ-036 LAT=1 with back-to-back port 0 reads at addresses 0 and 1 -> acks 4 cycles apart, rdata0 matches each read in order.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port arbiter in front of a single memory with a fixed
// read latency. Port 0 is instruction fetch, port 1 is data load/store.
// Only one access is outstanding at a time; each access occupies the
// arbiter for LAT+3 cycles (IDLE sample, ISSUE, LAT x WAIT, RESP).
//
// Parameters
//   LAT        memory read latency in cycles (1..15)
//   FIXED_PRIO 0 = round-robin on ties, 1 = port 0 always wins
//
// Ports
//   clk                 clock, all state changes on posedge
//   reset               synchronous active-low reset
//   req0/req1           access request per port
//   we0/we1             1 = write, 0 = read (qualified by req)
//   addr0/addr1         16-bit word address
//   wdata0/wdata1       16-bit write data
//   gnt0/gnt1           one-cycle pulse in the ISSUE cycle of that port
//   ack0/ack1           one-cycle pulse in the RESP cycle of that port
//   rdata0/rdata1       read data, held until the next read of that port
//   mem_en/mem_we       memory strobe / write enable (ISSUE cycle only)
//   mem_addr/mem_wdata  memory address / write data, held between accesses
//   mem_rdata           memory read data, valid LAT cycles after mem_en
module mem_arbiter #(
    parameter int LAT        = 2,
    parameter int FIXED_PRIO = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [15:0] addr0,
    input  logic [15:0] addr1,
    input  logic [15:0] wdata0,
    input  logic [15:0] wdata1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        ack0,
    output logic        ack1,
    output logic [15:0] rdata0,
    output logic [15:0] rdata1,
    output logic        mem_en,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [3:0] LAT_C = 4'(LAT);

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic        last_q;     // port granted most recently
    logic        win_q;      // port owning the access in flight
    logic        cmd_we_q;   // access in flight is a write
    logic        win_d;
    logic        gnt0_q, gnt1_q, ack0_q, ack1_q;
    logic        mem_en_q, mem_we_q;
    logic [15:0] mem_addr_q, mem_wdata_q;
    logic [15:0] rdata0_q, rdata1_q;

    // Winner for the current IDLE sample. With a single requester it wins
    // outright; on a tie either port 0 (fixed) or the port not granted last.
    always_comb begin
        win_d = ~req0;
        if (req0 && req1) begin
            win_d = (FIXED_PRIO != 0) ? 1'b0 : ~last_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            last_q      <= 1'b1;   // port 0 wins the first tie
            win_q       <= 1'b0;
            cmd_we_q    <= 1'b0;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 16'd0;
            mem_wdata_q <= 16'd0;
            rdata0_q    <= 16'd0;
            rdata1_q    <= 16'd0;
        end else begin
            // Pulse outputs default low; they are raised for exactly one
            // cycle by the transition that enters ISSUE or RESP.
            gnt0_q   <= 1'b0;
            gnt1_q   <= 1'b0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            mem_en_q <= 1'b0;
            mem_we_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req0 || req1) begin
                        win_q       <= win_d;
                        last_q      <= win_d;
                        cmd_we_q    <= win_d ? we1 : we0;
                        mem_en_q    <= 1'b1;
                        mem_we_q    <= win_d ? we1 : we0;
                        mem_addr_q  <= win_d ? addr1 : addr0;
                        mem_wdata_q <= win_d ? wdata1 : wdata0;
                        gnt0_q      <= ~win_d;
                        gnt1_q      <= win_d;
                        state_q     <= ISSUE;
                    end
                end
                ISSUE: begin
                    // Counter tracks which of the LAT wait cycles we are in.
                    cnt_q   <= 4'd1;
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (cnt_q == LAT_C) begin
                        if (!cmd_we_q) begin
                            if (win_q) begin
                                rdata1_q <= mem_rdata;
                            end else begin
                                rdata0_q <= mem_rdata;
                            end
                        end
                        ack0_q  <= ~win_q;
                        ack1_q  <= win_q;
                        cnt_q   <= 4'd0;
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign gnt0      = gnt0_q;
    assign gnt1      = gnt1_q;
    assign ack0      = ack0_q;
    assign ack1      = ack1_q;
    assign rdata0    = rdata0_q;
    assign rdata1    = rdata1_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter. Three instances: 0 = LAT 2 round-robin,
// 1 = LAT 2 fixed priority, 2 = LAT 1 round-robin. A transaction-level
// reference model predicts, for every cycle, the grant/ack/strobe outputs
// and the held address/data/read-data values of each instance.
`timescale 1ns/1ps
module tb_mem_arbiter;

    localparam int NI = 3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NI-1:0]   req0_s, req1_s, we0_s, we1_s;
    logic [NI-1:0]   gnt0_s, gnt1_s, ack0_s, ack1_s, mem_en_s, mem_we_s;
    logic [15:0]     addr0_s [NI];
    logic [15:0]     addr1_s [NI];
    logic [15:0]     wdata0_s [NI];
    logic [15:0]     wdata1_s [NI];
    logic [15:0]     rdata0_s [NI];
    logic [15:0]     rdata1_s [NI];
    logic [15:0]     mem_addr_s [NI];
    logic [15:0]     mem_wdata_s [NI];
    logic [15:0]     mem_rdata_s [NI];

    always #5 clk = ~clk;

    genvar gi;
    generate
        for (gi = 0; gi < NI; gi++) begin : g_dut
            mem_arbiter #(
                .LAT        ((gi == 2) ? 1 : 2),
                .FIXED_PRIO ((gi == 1) ? 1 : 0)
            ) u_dut (
                .clk       (clk),
                .reset     (rst_n),
                .req0      (req0_s[gi]),
                .req1      (req1_s[gi]),
                .we0       (we0_s[gi]),
                .we1       (we1_s[gi]),
                .addr0     (addr0_s[gi]),
                .addr1     (addr1_s[gi]),
                .wdata0    (wdata0_s[gi]),
                .wdata1    (wdata1_s[gi]),
                .gnt0      (gnt0_s[gi]),
                .gnt1      (gnt1_s[gi]),
                .ack0      (ack0_s[gi]),
                .ack1      (ack1_s[gi]),
                .rdata0    (rdata0_s[gi]),
                .rdata1    (rdata1_s[gi]),
                .mem_en    (mem_en_s[gi]),
                .mem_we    (mem_we_s[gi]),
                .mem_addr  (mem_addr_s[gi]),
                .mem_wdata (mem_wdata_s[gi]),
                .mem_rdata (mem_rdata_s[gi])
            );
        end
    endgenerate

    // ---------------- reference model state ----------------
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          free_c [NI];   // first cycle the arbiter is idle again
    int          iss_c  [NI];   // predicted ISSUE cycle of latest access
    int          ack_c  [NI];   // predicted RESP cycle of latest access
    int          resp_c [NI];   // cycle in which memory returns read data
    logic [15:0] resp_a [NI];
    bit          win_m  [NI];
    bit          last_m [NI];
    bit          we_m   [NI];
    logic [15:0] addr_m [NI];
    logic [15:0] exp_maddr [NI];
    logic [15:0] exp_mwdata [NI];
    logic [15:0] exp_rd0 [NI];
    logic [15:0] exp_rd1 [NI];
    logic [15:0] store [NI][256];
    bit          rand_en [NI];
    bit          hold0 [NI];
    bit          hold1 [NI];

    function automatic int lat_of(input int k);
        return (k == 2) ? 1 : 2;
    endfunction

    task automatic check(input string tag, input int k, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s inst%0d cyc%0d: got %h expected %h", tag, k, cyc, obs, expv);
        end
    endtask

    // Decisions taken at the edge that ends the current cycle.
    task automatic model_edge();
        for (int k = 0; k < NI; k++) begin
            bit r0;
            bit r1;
            bit w;
            r0 = req0_s[k];
            r1 = req1_s[k];
            if (!rst_n) begin
                free_c[k]     = cyc + 1;
                iss_c[k]      = -1;
                ack_c[k]      = -1;
                last_m[k]     = 1'b1;
                exp_maddr[k]  = 16'd0;
                exp_mwdata[k] = 16'd0;
                exp_rd0[k]    = 16'd0;
                exp_rd1[k]    = 16'd0;
            end else begin
                if (ack_c[k] == cyc + 1 && !we_m[k]) begin
                    if (win_m[k]) exp_rd1[k] = store[k][addr_m[k][7:0]];
                    else          exp_rd0[k] = store[k][addr_m[k][7:0]];
                end
                if (cyc >= free_c[k] && (r0 || r1)) begin
                    if (r0 && r1) w = (k == 1) ? 1'b0 : ~last_m[k];
                    else          w = ~r0;
                    win_m[k]      = w;
                    last_m[k]     = w;
                    we_m[k]       = w ? we1_s[k] : we0_s[k];
                    addr_m[k]     = w ? addr1_s[k] : addr0_s[k];
                    exp_maddr[k]  = addr_m[k];
                    exp_mwdata[k] = w ? wdata1_s[k] : wdata0_s[k];
                    iss_c[k]      = cyc + 1;
                    ack_c[k]      = cyc + 2 + lat_of(k);
                    free_c[k]     = cyc + 3 + lat_of(k);
                    if (we_m[k]) begin
                        store[k][addr_m[k][7:0]] = exp_mwdata[k];
                        resp_c[k] = -1;
                    end else begin
                        resp_c[k] = cyc + 1 + lat_of(k);
                        resp_a[k] = addr_m[k];
                    end
                end
            end
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < NI; k++) begin
            check("gnt0", k, 16'(gnt0_s[k]), 16'(cyc == iss_c[k] && !win_m[k]));
            check("gnt1", k, 16'(gnt1_s[k]), 16'(cyc == iss_c[k] && win_m[k]));
            check("ack0", k, 16'(ack0_s[k]), 16'(cyc == ack_c[k] && !win_m[k]));
            check("ack1", k, 16'(ack1_s[k]), 16'(cyc == ack_c[k] && win_m[k]));
            check("mem_en", k, 16'(mem_en_s[k]), 16'(cyc == iss_c[k]));
            check("mem_we", k, 16'(mem_we_s[k]), 16'(cyc == iss_c[k] && we_m[k]));
            check("mem_addr", k, mem_addr_s[k], exp_maddr[k]);
            check("mem_wdata", k, mem_wdata_s[k], exp_mwdata[k]);
            check("rdata0", k, rdata0_s[k], exp_rd0[k]);
            check("rdata1", k, rdata1_s[k], exp_rd1[k]);
        end
    endtask

    task automatic rand_drive();
        for (int k = 0; k < NI; k++) begin
            if (rand_en[k]) begin
                if (cyc == iss_c[k]) begin
                    if (win_m[k]) hold1[k] = 1'b0;
                    else          hold0[k] = 1'b0;
                end
                if (!hold0[k]) begin
                    hold0[k]    = ($urandom_range(0, 2) == 0);
                    req0_s[k]   = hold0[k];
                    we0_s[k]    = 1'($urandom_range(0, 1));
                    addr0_s[k]  = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
                    wdata0_s[k] = 16'($urandom);
                end
                if (!hold1[k]) begin
                    hold1[k]    = ($urandom_range(0, 2) == 0);
                    req1_s[k]   = hold1[k];
                    we1_s[k]    = 1'($urandom_range(0, 1));
                    addr1_s[k]  = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
                    wdata1_s[k] = 16'($urandom);
                end
            end
        end
    endtask

    task automatic tick();
        for (int k = 0; k < NI; k++) begin
            mem_rdata_s[k] = (resp_c[k] == cyc) ? store[k][resp_a[k][7:0]] : 16'($urandom);
        end
        model_edge();
        @(posedge clk);
        #1;
        cyc++;
        check_all();
        rand_drive();
    endtask

    // which: 0 gnt0, 1 gnt1, 2 ack0, 3 ack1, other = any grant
    task automatic wait_ev(input int k, input int which, input int budget, output int at);
        bit seen;
        seen = 1'b0;
        at   = -1;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            case (which)
                0:       seen = gnt0_s[k];
                1:       seen = gnt1_s[k];
                2:       seen = ack0_s[k];
                3:       seen = ack1_s[k];
                default: seen = gnt0_s[k] | gnt1_s[k];
            endcase
            if (seen) at = cyc;
        end
        checks++;
        assert (seen) else begin
            errors++;
            $error("FAIL wait%0d inst%0d cyc%0d: event absent, expected within %0d cycles", which, k, cyc, budget);
        end
    endtask

    initial begin
        int tg, ta, a1, a2, prev, cnt, n0, n1, crel;
        rst_n = 1'b0;
        for (int k = 0; k < NI; k++) begin
            req0_s[k] = 1'b0; req1_s[k] = 1'b0; we0_s[k] = 1'b0; we1_s[k] = 1'b0;
            addr0_s[k] = 16'd0; addr1_s[k] = 16'd0; wdata0_s[k] = 16'd0; wdata1_s[k] = 16'd0;
            mem_rdata_s[k] = 16'd0;
            free_c[k] = 0; iss_c[k] = -1; ack_c[k] = -1; resp_c[k] = -1; resp_a[k] = 16'd0;
            win_m[k] = 1'b0; last_m[k] = 1'b1; we_m[k] = 1'b0; addr_m[k] = 16'd0;
            exp_maddr[k] = 16'd0; exp_mwdata[k] = 16'd0; exp_rd0[k] = 16'd0; exp_rd1[k] = 16'd0;
            rand_en[k] = 1'b0; hold0[k] = 1'b0; hold1[k] = 1'b0;
            for (int a = 0; a < 256; a++) store[k][a] = 16'($urandom);
        end
        repeat (3) tick();

        // Single read on port 0, arbitration in the first cycle out of reset.
        store[0][8'h10] = 16'hBEEF;
        rst_n = 1'b1;
        req0_s[0] = 1'b1; we0_s[0] = 1'b0; addr0_s[0] = 16'h0010; wdata0_s[0] = 16'h5555;
        crel = cyc;
        wait_ev(0, 0, 4, tg);
        check("rd_gnt_cycle", 0, 16'(tg), 16'(crel + 1));
        check("rd_mem_en", 0, 16'(mem_en_s[0]), 16'd1);
        check("rd_mem_addr", 0, mem_addr_s[0], 16'h0010);
        req0_s[0] = 1'b0;
        wait_ev(0, 2, 6, ta);
        check("rd_ack_delay", 0, 16'(ta - tg), 16'd3);
        check("rd_rdata0", 0, rdata0_s[0], 16'hBEEF);

        // Write on port 1 to the top address.
        req1_s[0] = 1'b1; we1_s[0] = 1'b1; addr1_s[0] = 16'hFFFF; wdata1_s[0] = 16'h1234;
        wait_ev(0, 1, 6, tg);
        check("wr_mem_we", 0, 16'(mem_we_s[0]), 16'd1);
        check("wr_mem_addr", 0, mem_addr_s[0], 16'hFFFF);
        check("wr_mem_wdata", 0, mem_wdata_s[0], 16'h1234);
        req1_s[0] = 1'b0;
        wait_ev(0, 3, 6, ta);
        check("wr_ack_delay", 0, 16'(ta - tg), 16'd3);
        check("wr_rdata1_held", 0, rdata1_s[0], 16'h0000);
        check("wr_rdata0_held", 0, rdata0_s[0], 16'hBEEF);

        // Request pulse that vanishes before the IDLE sampling edge.
        tick();
        req0_s[0] = 1'b1;
        #3;
        req0_s[0] = 1'b0;
        cnt = 0;
        repeat (6) begin
            tick();
            cnt += int'(gnt0_s[0]) + int'(gnt1_s[0]);
        end
        check("glitch_no_gnt", 0, 16'(cnt), 16'd0);

        // Continuous tie from reset release: alternating grants, 5 apart.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        req0_s[0] = 1'b1; we0_s[0] = 1'b0; addr0_s[0] = 16'h0100;
        req1_s[0] = 1'b1; we1_s[0] = 1'b0; addr1_s[0] = 16'h0201;
        prev = -1;
        for (int i = 0; i < 4; i++) begin
            wait_ev(0, 4, 8, tg);
            check("tie_port", 0, 16'(gnt1_s[0]), 16'(i % 2));
            if (i > 0) check("tie_spacing", 0, 16'(tg - prev), 16'd5);
            prev = tg;
        end
        req0_s[0] = 1'b0; req1_s[0] = 1'b0;
        repeat (8) tick();

        // Reset in cycle T+1 of a port 0 read aborts it.
        req0_s[0] = 1'b1; we0_s[0] = 1'b0; addr0_s[0] = 16'h0020;
        wait_ev(0, 0, 4, tg);
        req0_s[0] = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        check("abort_mem_en", 0, 16'(mem_en_s[0]), 16'd0);
        check("abort_mem_addr", 0, mem_addr_s[0], 16'h0000);
        check("abort_mem_wdata", 0, mem_wdata_s[0], 16'h0000);
        check("abort_rdata0", 0, rdata0_s[0], 16'h0000);
        check("abort_rdata1", 0, rdata1_s[0], 16'h0000);
        rst_n = 1'b1;
        cnt = 0;
        repeat (6) begin
            tick();
            cnt += int'(ack0_s[0]) + int'(ack1_s[0]);
        end
        check("abort_no_ack", 0, 16'(cnt), 16'd0);
        store[0][8'h30] = 16'hC0DE;
        req0_s[0] = 1'b1; addr0_s[0] = 16'h0030;
        wait_ev(0, 0, 4, tg);
        req0_s[0] = 1'b0;
        wait_ev(0, 2, 6, ta);
        check("after_abort_rdata0", 0, rdata0_s[0], 16'hC0DE);

        // Fixed priority: port 0 starves port 1 while it keeps requesting.
        req0_s[1] = 1'b1; we0_s[1] = 1'b0; addr0_s[1] = 16'h0044;
        req1_s[1] = 1'b1; we1_s[1] = 1'b0; addr1_s[1] = 16'h0055;
        n0 = 0; n1 = 0;
        for (int i = 0; i < 3; i++) begin
            wait_ev(1, 4, 8, tg);
            n0 += int'(gnt0_s[1]);
            n1 += int'(gnt1_s[1]);
        end
        req0_s[1] = 1'b0;
        wait_ev(1, 4, 8, tg);
        check("fp_gnt0_count", 1, 16'(n0), 16'd3);
        check("fp_gnt1_count", 1, 16'(n1), 16'd0);
        check("fp_next_is_port1", 1, 16'(gnt1_s[1]), 16'd1);
        req1_s[1] = 1'b0;

        // LAT=1 back-to-back reads on port 0.
        store[2][8'h00] = 16'hA0A0;
        store[2][8'h01] = 16'hB1B1;
        req0_s[2] = 1'b1; we0_s[2] = 1'b0; addr0_s[2] = 16'h0000;
        wait_ev(2, 0, 4, tg);
        addr0_s[2] = 16'h0001;
        wait_ev(2, 2, 4, a1);
        check("lat1_rdata_first", 2, rdata0_s[2], 16'hA0A0);
        wait_ev(2, 2, 6, a2);
        check("lat1_rdata_second", 2, rdata0_s[2], 16'hB1B1);
        check("lat1_ack_spacing", 2, 16'(a2 - a1), 16'd4);
        req0_s[2] = 1'b0;
        repeat (4) tick();

        // Randomized traffic on all instances with occasional resets.
        for (int k = 0; k < NI; k++) rand_en[k] = 1'b1;
        repeat (2500) begin
            rst_n = ($urandom_range(0, 299) != 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
